// File: rtl/bram_stream_reader_pkg.sv
// Shared defaults, RAM timing and FSM encoding for the BRAM stream reader.
package bram_stream_reader_pkg;

  localparam int unsigned ADDR_W_DEF  = 14;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned BRAM_RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/bram_stream_reader_if.sv
// Valid/ready stream carrying data words plus an end-of-transfer marker.
interface bram_stream_reader_if
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/bram_stream_reader_sync_fifo_fwft.sv
// First-word-fall-through FIFO; head entry and valid come straight from registers.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    full      = (count == DEPTH_V);
    out_valid = (count != '0);
    out_data  = mem[rd_ptr];
    pop_ok    = out_valid && pop;
    push_ok   = push && (!full || pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Sequential block-RAM read master: streams `length` words from `base_addr`
// with credit-based flow control so the output FIFO can never overflow.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      length,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    bram_addr,
  output logic                 bram_we,
  output logic [DATA_W-1:0]    bram_din,
  input  logic [DATA_W-1:0]    bram_dout,
  bram_stream_reader_if.master strm
);

  localparam int unsigned   PIPE    = BRAM_RD_LAT + 1;
  localparam int unsigned   CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_V = (CW + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W:0]   remaining;
  logic [PIPE-1:0]   vld_pipe;
  logic [PIPE-1:0]   lst_pipe;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W:0]   fifo_out;
  logic              fifo_valid;
  logic              launch;
  logic              can_issue;
  logic              issue;
  logic              issue_last;
  logic              last_fire;
  logic [CW:0]       credit_sum;

  assign bram_we  = 1'b0;
  assign bram_din = '0;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_FIN);

  // The first read is launched straight from IDLE so the address reaches the
  // RAM one cycle after start; later reads are credit-gated in RUN.
  always_comb begin
    credit_sum = {1'b0, fifo_count} + {1'b0, inflight};
    launch     = (state == ST_IDLE) && start;
    can_issue  = (state == ST_RUN) && (remaining != '0) && (credit_sum < DEPTH_V);
    issue      = (launch && (length != '0)) || can_issue;
    issue_last = launch ? (length == LEN_ONE) : (remaining == LEN_ONE);
    last_fire  = strm.m_valid && strm.m_ready && strm.m_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bram_addr <= '0;
      next_addr <= '0;
      remaining <= '0;
      vld_pipe  <= '0;
      lst_pipe  <= '0;
      inflight  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[PIPE-2:0], issue};
      lst_pipe <= {lst_pipe[PIPE-2:0], issue && issue_last};
      case ({issue, vld_pipe[PIPE-1]})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (length == '0) begin
              state <= ST_FIN;
            end else begin
              state     <= ST_RUN;
              bram_addr <= base_addr;
              next_addr <= base_addr + 1'b1;
              remaining <= length - 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (remaining == '0) begin
            state <= ST_DRAIN;
          end else if (can_issue) begin
            bram_addr <= next_addr;
            next_addr <= next_addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_ONE) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (last_fire) begin
            state <= ST_FIN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_pipe[PIPE-1]),
    .push_data ({lst_pipe[PIPE-1], bram_dout}),
    .pop       (strm.m_ready),
    .out_data  (fifo_out),
    .out_valid (fifo_valid),
    .count     (fifo_count)
  );

  assign strm.m_data  = fifo_out[DATA_W-1:0];
  assign strm.m_last  = fifo_out[DATA_W];
  assign strm.m_valid = fifo_valid;

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read master for one port of the team's 16K x 32 block RAM: given a base address and word count, issues sequential reads and emits the words as a valid/ready stream with a last flag.
- Absorbs the RAM's fixed 1-cycle registered read latency and downstream backpressure with a small credit-controlled FIFO. Never writes the RAM.
- Sits between a block RAM port (addr/we/din/dout) and a streaming consumer such as a DMA, UART or compute stage.

Parameters:
- ADDR_W, 14, RAM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 32, RAM word width.
- FIFO_DEPTH, 4, output buffer entries; power of two, minimum 4. Depth 4 sustains 1 word/cycle.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; sampled with start.
- length  in  ADDR_W+1  word count, 0..2^ADDR_W; sampled with start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- bram_addr  out  ADDR_W  RAM port address.
- bram_we  out  1  tied 0.
- bram_din  out  DATA_W  tied 0.
- bram_dout  in  DATA_W  RAM registered read data, valid 1 cycle after the address.
- m_data  out  DATA_W  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks the final word.

Behaviour:
- Reset values: busy=0, done=0, bram_addr=0, m_valid=0, m_last=0, m_data=0. FIFO emptied, counters cleared, state IDLE.
- States:
  - IDLE -> RUN on start with length!=0.
  - IDLE -> FIN on start with length==0.
  - RUN -> DRAIN when the last read is issued.
  - DRAIN -> FIN when the last word handshakes (m_valid & m_ready & m_last).
  - FIN -> IDLE, with done=1 during FIN.
- busy=1 in RUN, DRAIN and FIN. start is ignored while busy=1.
- Issue rule: a read is issued in a cycle when state is RUN and fifo_count + inflight < FIFO_DEPTH.
  - bram_addr is registered and presents the issued address.
  - A 1-bit valid pipeline tracks the read. At the next edge, bram_dout is pushed into the FIFO together with a last tag (remaining==1 at issue).
- Address increments by 1 per issue and wraps 2^ADDR_W-1 -> 0. The remaining count decrements per issue.
- When idle, bram_addr holds its last value. Reads while idle are harmless.
- Latency: start high in cycle 0 -> first address in cycle 1 -> bram_dout valid in cycle 2 -> m_valid=1 in cycle 3 (FIFO registered output).
- Throughput: with m_ready held high, one word per cycle, no bubbles.
- Stream rules (AXI-style):
  - Once m_valid=1, m_data and m_last hold stable until m_ready=1.
  - m_valid never depends combinationally on m_ready.
  - Words are emitted in address order; exactly `length` words per transfer.
- FIFO full with reads in flight: cannot happen, because the credit rule guarantees space. A same-cycle push and pop leaves the count unchanged.
- done pulses in the cycle after the last handshake; busy falls with the end of that cycle.
- length==2^ADDR_W: the full RAM is read, and the address returns to base.
- rst asserted mid-transfer: the transfer is aborted, the FIFO and in-flight data are discarded, no done pulse is produced, and the block is in IDLE the next cycle.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, the BRAM read latency constant (1), and the state encoding enum (IDLE, RUN, DRAIN, FIN).
- One sub-module, sync_fifo_fwft: parameterised DATA_W+1 wide (data + last), depth FIFO_DEPTH, registered outputs, exposes count. It is reusable by other stream blocks.

Test Plan:
1. RAM preloaded mem[a]=a*3; base=0x010, length=5, m_ready=1 -> words 0x30,0x33,0x36,0x39,0x3C on consecutive cycles starting cycle 3; m_last only on 0x3C; done one cycle after.
2. Same as 1 with m_ready toggling 1,0,0,1 pseudo-randomly -> identical word sequence, data stable while stalled, at most FIFO_DEPTH words outstanding, bram_we never 1.
3. base=0x3FFE, length=4 -> addresses 0x3FFE,0x3FFF,0x0000,0x0001 observed on bram_addr; data matches; m_last on the fourth word.
4. length=0 -> no m_valid, done pulses in cycle 1, busy high for exactly one cycle.
5. start asserted again mid-transfer with different base -> ignored; the original 5 words complete. rst asserted after 2 words -> m_valid=0, busy=0 next cycle, no done; a new start then runs cleanly.
6. length=16384, base=0, m_ready=1 -> 16384 words in 16384 consecutive cycles; the last word is mem[0x3FFF].
